alu_pipe_wrapper: RTL
=====================

// Module: alu_pipe_wrapper
// PURPOSE
//  Parametrised, handshaked successor of the registered ALU wrapper.
//  - Registers operands, computes one ALU op, registers result, flags and carry.
//  - Full valid/ready flow control, so it can sit between stalling producers/consumers.
//  - Optional accumulate mode chains the last computed result back as operand A.
// PARAMETERS
//  WIDTH    8  operand/result width (>=4)
//  REG_IN   1  1: input register stage present (latency 2); 0: bypassed (latency 1)
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  op         in   3      opcode (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  acc_en     in   1      1: use internal accumulator instead of a
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  ALU result
//  alu_flag   out  4      {Z,N,V,P}
//  carry      out  1      carry/borrow/shifted-out bit
// BEHAVIOUR
//  Reset (async, rst=1): all valids=0, result=0, alu_flag=0, carry=0, acc=0, stage data=0.
//  in_ready=0 during reset.
//  Ops (3 bits):
//    0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a;
//    6 SHL a by 1; 7 SHR a by 1 (logical).
//  Arithmetic: computed in WIDTH+1 bits, result = low WIDTH bits.
//    ADD: carry = bit WIDTH.
//    SUB: carry = borrow (1 when a<b unsigned).
//    SHL: carry = a[WIDTH-1]. SHR: carry = a[0]. Logic ops: carry=0.
//  Flags:
//    Z = (result==0). N = result[WIDTH-1]. P = ~^result (1 = even parity).
//    V (signed overflow): ADD/SUB only, else 0.
//      ADD: a,b same sign and result sign differs.
//      SUB: a,b signs differ and result sign differs from a.
//  Pipeline: S1 = input register (skipped if REG_IN=0); S2 = output register.
//    ALU logic is combinational between S1 and S2.
//    Each stage holds a valid bit and advances when empty or when its downstream consumes.
//    Stall: out_valid & ~out_ready holds S2.
//      S1 then holds if full; in_ready = ~S1_valid | S2 advancing.
//    Full throughput: one beat/cycle with out_ready=1. No beat dropped or duplicated.
//    Output stability: result, alu_flag and carry are stable while out_valid & ~out_ready.
//  Accumulator:
//    - acc (WIDTH bits) loads the ALU result whenever a beat moves into S2.
//    - The acc_en flag travels with its beat. When set, the ALU uses acc in place of A,
//      evaluated at S1->S2 transfer.
//    - Back-to-back acc_en beats therefore chain with no bubble.
//    - acc is unaffected by stalls and is cleared only by reset.
//  Boundaries:
//    - Simultaneous S2 consume and S1 refill in the same cycle is legal: beat passes.
//    - Inputs with in_valid=0 are ignored; op/a/b are don't-care then.
//    - Reset mid-stream discards all in-flight beats; the first post-reset acc_en beat uses acc=0.
// STRUCTURE
//  Shared package alu_pkg:
//    - op_e enum (OP_ADD..OP_SHR)
//    - flag index localparams FLG_Z=3, FLG_N=2, FLG_V=1, FLG_P=0
//  Sub-module alu_core #(WIDTH): purely combinational
//    - inputs: op, a, b
//    - outputs: result, flag, carry
//  Wrapper holds: stage registers, valid/ready logic, acc register.
// TESTING (WIDTH=8, REG_IN=1 unless noted)
//  ADD 0x7F+0x01 -> result 0x80, flag {Z0,N1,V1,P0}, carry 0; out_valid 2 cycles after accept.
//  ADD 0xFF+0x01 -> 0x00, Z=1, P=1, carry 1.
//  SUB 0x00-0x01 -> 0xFF, N=1, carry(borrow) 1, V=0.
//  SHR 0x81 -> 0x40, carry 1.
//  Acc chain, out_ready=1:
//    - beats ADD a=5,b=3; then acc_en ADD b=2; then acc_en SHL.
//    - results 0x08, 0x0A, 0x14 on consecutive cycles.
//  Backpressure and reset:
//    - 4 beats streamed, out_ready low 3 cycles: in_ready drops, all 4 results delivered
//      in order, outputs held stable.
//    - assert rst mid-stream: out_valid 0 immediately, outputs 0.
//    - with REG_IN=0, ADD 1+1 appears after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode enum and flag bit positions for the pipelined ALU wrapper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  localparam int unsigned FLG_W = 4;
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_V = 1;
  localparam int unsigned FLG_P = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: one op on a/b, producing result, {Z,N,V,P} flags and carry.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [FLG_W-1:0] flag,
  output logic             carry
);

  logic [WIDTH:0] w_ext;
  logic           w_v;

  always_comb begin
    w_ext  = '0;
    w_v    = 1'b0;
    carry  = 1'b0;
    result = '0;
    case (op)
      OP_ADD: begin
        w_ext  = {1'b0, a} + {1'b0, b};
        result = w_ext[WIDTH-1:0];
        carry  = w_ext[WIDTH];
        w_v    = (a[WIDTH-1] == b[WIDTH-1]) && (w_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow (a < b unsigned).
        w_ext  = {1'b0, a} - {1'b0, b};
        result = w_ext[WIDTH-1:0];
        carry  = w_ext[WIDTH];
        w_v    = (a[WIDTH-1] != b[WIDTH-1]) && (w_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end

  always_comb begin
    flag        = '0;
    flag[FLG_Z] = (result == '0);
    flag[FLG_N] = result[WIDTH-1];
    flag[FLG_V] = w_v;
    flag[FLG_P] = ~^result;
  end

endmodule

// File: rtl/alu_pipe_wrapper.sv
// Handshaked ALU pipeline: optional operand register (S1), ALU, result register (S2),
// plus an accumulator that can replace operand A for chained computations.
module alu_pipe_wrapper
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned REG_IN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flag,
  output logic             carry
);

  logic             w_s1_valid;
  op_e              w_s1_op;
  logic [WIDTH-1:0] w_s1_a;
  logic [WIDTH-1:0] w_s1_b;
  logic             w_s1_acc;

  logic             w_s2_adv;
  logic             w_s2_load;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flag;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_res;
  logic [FLG_W-1:0] w_alu_flag;
  logic             w_alu_carry;

  assign w_s2_adv  = ~r_s2_valid | out_ready;
  assign w_s2_load = w_s1_valid & w_s2_adv;

  generate
    if (REG_IN != 0) begin : g_s1
      logic             r_s1_valid;
      op_e              r_s1_op;
      logic [WIDTH-1:0] r_s1_a;
      logic [WIDTH-1:0] r_s1_b;
      logic             r_s1_acc;
      logic             w_s1_adv;

      assign w_s1_adv = ~r_s1_valid | w_s2_adv;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s1_valid <= 1'b0;
          r_s1_op    <= OP_ADD;
          r_s1_a     <= '0;
          r_s1_b     <= '0;
          r_s1_acc   <= 1'b0;
        end else if (w_s1_adv) begin
          r_s1_valid <= in_valid;
          if (in_valid) begin
            r_s1_op  <= op_e'(op);
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_acc <= acc_en;
          end
        end
      end

      assign in_ready   = ~rst & w_s1_adv;
      assign w_s1_valid = r_s1_valid;
      assign w_s1_op    = r_s1_op;
      assign w_s1_a     = r_s1_a;
      assign w_s1_b     = r_s1_b;
      assign w_s1_acc   = r_s1_acc;
    end else begin : g_s1_bypass
      assign in_ready   = ~rst & w_s2_adv;
      assign w_s1_valid = in_valid;
      assign w_s1_op    = op_e'(op);
      assign w_s1_a     = a;
      assign w_s1_b     = b;
      assign w_s1_acc   = acc_en;
    end
  endgenerate

  // acc is read at the S1->S2 transfer, so back-to-back acc_en beats see the previous result.
  assign w_alu_a = w_s1_acc ? r_acc : w_s1_a;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op     (w_s1_op),
    .a      (w_alu_a),
    .b      (w_s1_b),
    .result (w_alu_res),
    .flag   (w_alu_flag),
    .carry  (w_alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flag     <= '0;
      r_carry    <= 1'b0;
      r_acc      <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= w_s1_valid;
      end
      if (w_s2_load) begin
        r_result <= w_alu_res;
        r_flag   <= w_alu_flag;
        r_carry  <= w_alu_carry;
        r_acc    <= w_alu_res;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign alu_flag  = r_flag;
  assign carry     = r_carry;

endmodule
